// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into SLICE-bit stages with valid/ready flow control.
// Optional build macro ADDSUB_SATURATE_EN clamps z on signed overflow instead of wrapping.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGE = (WIDTH + SLICE - 1) / SLICE;
  localparam int L      = NSTAGE - 1;

  // Each stage keeps the full operand/result words; stage k owns bits [k*SLICE +: SLICE].
  logic [WIDTH-1:0]  x_q [NSTAGE];
  logic [WIDTH-1:0]  x_d [NSTAGE];
  logic [WIDTH-1:0]  y_q [NSTAGE];
  logic [WIDTH-1:0]  y_d [NSTAGE];
  logic [WIDTH-1:0]  z_q [NSTAGE];
  logic [WIDTH-1:0]  z_d [NSTAGE];
  logic [NSTAGE-1:0] c_q, c_d;
  logic [NSTAGE-1:0] vld_q, vld_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  assign out_valid = vld_q[L];
  assign in_ready  = !(out_valid && !out_ready);
  assign z         = z_q[L];
  assign cout      = c_q[L];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  always_comb begin
    logic [WIDTH-1:0] xs, ys, zs;
    logic             cs, vs, xb, yb;
    int               p;
    xs = '0; ys = '0; zs = '0; cs = 1'b0; vs = 1'b0; xb = 1'b0; yb = 1'b0; p = 0;
    for (int k = 0; k < NSTAGE; k++) begin
      p = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        xs = x;
        ys = y ^ {WIDTH{control}};
        zs = '0;
        cs = control;
        vs = in_valid;
      end else begin
        xs = x_q[p];
        ys = y_q[p];
        zs = z_q[p];
        cs = c_q[p];
        vs = vld_q[p];
      end
      // Ripple only this stage's slice; the last slice may be narrower.
      for (int b = 0; b < SLICE; b++) begin
        if (k * SLICE + b < WIDTH) begin
          xb = xs[k*SLICE+b];
          yb = ys[k*SLICE+b];
          zs[k*SLICE+b] = xb ^ yb ^ cs;
          cs = (xb & yb) | (cs & (xb ^ yb));
        end
      end
      x_d[k]   = xs;
      y_d[k]   = ys;
      z_d[k]   = zs;
      c_d[k]   = cs;
      vld_d[k] = vs;
    end
    ovf_d = (x_d[L][WIDTH-1] == y_d[L][WIDTH-1]) && (z_d[L][WIDTH-1] != x_d[L][WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    if (ovf_d)
      z_d[L] = x_d[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    zero_d = (z_d[L] == '0);
  end

  // Whole pipeline advances together; a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
      end
      c_q    <= '0;
      vld_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (in_ready) begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      c_q    <= c_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe at WIDTH=8, SLICE=4 (two stages).
module tb_addsub_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, control, out_valid, out_ready;
  logic [7:0] x, y, z;
  logic       cout, ovf, zero;

  int checks   = 0;
  int failures = 0;

  addsub_pipe #(.WIDTH(8), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .control(control), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x, y;
    logic       ctl;
    logic [7:0] z;
    logic       co, ov, zr;
  } vec_t;

  logic [10:0] got[$];
  logic        mon_en = 1'b0;

  always @(negedge clk)
    if (mon_en && out_valid && out_ready) got.push_back({z, cout, ovf, zero});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t vt[9];
    vec_t op[4];
    int   i;
    vt[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vt[2] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[8] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_SATURATE_EN
    vt[5] = '{8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vt[6] = '{8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
    vt[7] = '{8'h80, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    op[2] = '{8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
`else
    vt[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vt[6] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vt[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    op[2] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0};
`endif
    op[0] = '{8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0};
    op[1] = '{8'h40, 8'h10, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0};
    op[3] = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; control = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_z", z, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single operations: latency and result per vector.
    for (int v = 0; v < 9; v++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; x = vt[v].x; y = vt[v].y; control = vt[v].ctl;
      @(posedge clk); #1;
      in_valid = 1'b0; x = 8'hAA; y = 8'h55; control = ~control;
      @(negedge clk);
      chk($sformatf("v%0d_early_valid", v), out_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", v), out_valid, 1);
      chk($sformatf("v%0d_z", v), z, vt[v].z);
      chk($sformatf("v%0d_cout", v), cout, vt[v].co);
      chk($sformatf("v%0d_ovf", v), ovf, vt[v].ov);
      chk($sformatf("v%0d_zero", v), zero, vt[v].zr);
    end

    // Back-to-back mixed ops with a 3-cycle output stall.
    @(posedge clk);
    got.delete();
    mon_en = 1'b1;
    i = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc < 6);
      if (i < 4) begin
        in_valid = 1'b1; x = op[i].x; y = op[i].y; control = op[i].ctl;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) begin
        chk($sformatf("stall%0d_in_ready", cyc), in_ready, 0);
        chk($sformatf("stall%0d_out_valid", cyc), out_valid, 1);
        chk($sformatf("stall%0d_z_held", cyc), z, op[1].z);
        chk($sformatf("stall%0d_cout_held", cyc), cout, op[1].co);
      end
      if (in_valid && in_ready) i++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk($sformatf("stall_res%0d", k), got[k], {op[k].z, op[k].co, op[k].ov, op[k].zr});

    // Reset with two operations in flight, then accept on the first edge after release.
    @(posedge clk); #1;
    got.delete();
    in_valid = 1'b1; x = 8'h01; y = 8'h01; control = 1'b0;
    @(posedge clk); #1;
    x = 8'h02; y = 8'h02;
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_z", z, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b1; x = 8'h21; y = 8'h12; control = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_early_valid", out_valid, 0);
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_z", z, 8'h33);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_count", got.size(), 1);
    if (got.size() > 0) chk("post_rst_res", got[0], {8'h33, 1'b0, 1'b0, 1'b0});
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
